// File: rtl/batcharger_adc_sched.sv
// Round-robin scheduler that shares one 8-bit ADC among the battery V/I/T monitors.
// Optional macro BATSCHED_AVG_EN: a valid channel stores the rounded mean of its old value and the new sample.
//
// state    | meaning
// S_IDLE   | pick the next enabled channel and drive it onto the mux
// S_SETTLE | mux held on the picked channel while the analog path settles
// S_CONV   | start pulse in the first cycle, then wait for adc_done or timeout
module batcharger_adc_sched #(
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       vmonen,
   input  logic       imonen,
   input  logic       tmonen,
   output logic [1:0] adc_sel,
   output logic       adc_start,
   input  logic       adc_done,
   input  logic [7:0] adc_data,
   output logic [7:0] vbat,
   output logic [7:0] ibat,
   output logic [7:0] tbat,
   output logic       vtok,
   output logic       adc_err
);

   localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] TMO_LD    = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CONV   = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [1:0]      sel_q;
   logic [1:0]      last_q;
   logic [1:0]      pick;
   logic [1:0]      c1, c2, c3;
   logic            pick_ok;
   logic            go;
   logic            conv_first;
   logic            done_hit;
   logic            tmo_hit;
   logic [3:0]      mon;
   logic            v_valid, i_valid, t_valid;
   logic [7:0]      wr_data;

   function automatic logic [1:0] nxt_ch(input logic [1:0] c);
      return (c == 2'd2) ? 2'd0 : c + 2'd1;
   endfunction

   assign mon = {1'b0, tmonen, imonen, vmonen};

   // Candidates in round-robin order starting after the last channel picked.
   always_comb begin
      c1      = nxt_ch(last_q);
      c2      = nxt_ch(c1);
      c3      = nxt_ch(c2);
      pick_ok = |mon;
      pick    = c3;
      if (mon[c1])
         pick = c1;
      else if (mon[c2])
         pick = c2;
   end

   assign go         = (state == S_IDLE) && en && pick_ok;
   assign conv_first = (state == S_CONV) && (cnt == TMO_LD);
   assign done_hit   = (state == S_CONV) && adc_done && !conv_first;
   assign tmo_hit    = (state == S_CONV) && (cnt == '0) && !done_hit;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      adc_start = conv_first;
      adc_sel   = go ? pick : sel_q;
      case (state)
         S_IDLE: begin
            if (go) begin
               state_nxt = S_SETTLE;
               cnt_nxt   = SETTLE_LD;
            end
         end
         S_SETTLE: begin
            if (cnt == '0) begin
               state_nxt = S_CONV;
               cnt_nxt   = TMO_LD;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         S_CONV: begin
            if (done_hit || tmo_hit) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
      if (!en) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         sel_q   <= 2'd0;
         last_q  <= 2'd2;
         v_valid <= 1'b0;
         i_valid <= 1'b0;
         t_valid <= 1'b0;
         adc_err <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (!en) begin
            v_valid <= 1'b0;
            i_valid <= 1'b0;
            t_valid <= 1'b0;
            adc_err <= 1'b0;
            last_q  <= 2'd2;
         end else if (go) begin
            sel_q  <= pick;
            last_q <= pick;
         end else if (done_hit) begin
            case (sel_q)
               2'd0:    v_valid <= 1'b1;
               2'd1:    i_valid <= 1'b1;
               default: t_valid <= 1'b1;
            endcase
         end else if (tmo_hit) begin
            // A dead channel loses its valid flag but keeps its last good data.
            case (sel_q)
               2'd0:    v_valid <= 1'b0;
               2'd1:    i_valid <= 1'b0;
               default: t_valid <= 1'b0;
            endcase
            adc_err <= 1'b1;
         end
      end
   end

`ifdef BATSCHED_AVG_EN
   logic [7:0] cur_old;
   logic       cur_valid;
   logic [8:0] sum;

   always_comb begin
      case (sel_q)
         2'd0: begin
            cur_old   = vbat;
            cur_valid = v_valid;
         end
         2'd1: begin
            cur_old   = ibat;
            cur_valid = i_valid;
         end
         default: begin
            cur_old   = tbat;
            cur_valid = t_valid;
         end
      endcase
      sum     = {1'b0, cur_old} + {1'b0, adc_data} + 9'd1;
      wr_data = cur_valid ? sum[8:1] : adc_data;
   end
`else
   assign wr_data = adc_data;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vbat <= 8'd0;
         ibat <= 8'd0;
         tbat <= 8'd0;
      end else if (en && done_hit) begin
         case (sel_q)
            2'd0:    vbat <= wr_data;
            2'd1:    ibat <= wr_data;
            default: tbat <= wr_data;
         endcase
      end
   end

   assign vtok = v_valid & t_valid;

endmodule
